id_ex_fwd_stage: RTL and testbench
==================================

Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register of the 5-stage pipelined CPU, merged with the EX-stage forwarding unit.
- Captures decoded operands, register addresses and control from ID each cycle.
- Presents them to EX together with the 2-bit operand selects that drive the two 4-way 32-bit operand muxes in front of the ALU.
- Supports hold on load-use stall and bubble insertion on flush.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register address width
CTRL_W, 7, control bundle width {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}
FUNCT_W, 10, {funct7, funct3} passed to ALU control

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
stall_i  input  1  hold current contents (load-use hazard)
flush_i  input  1  replace next contents with a bubble
rs1_data_i  input  DATA_W  register-file read data 1 from ID
rs2_data_i  input  DATA_W  register-file read data 2 from ID
imm_i  input  DATA_W  sign-extended immediate from ID
rs1_addr_i  input  REG_AW  source register 1 index
rs2_addr_i  input  REG_AW  source register 2 index
rd_addr_i  input  REG_AW  destination register index
ctrl_i  input  CTRL_W  decoded control bundle
funct_i  input  FUNCT_W  funct fields
exmem_regwrite_i  input  1  RegWrite of the instruction in EX/MEM
exmem_rd_i  input  REG_AW  rd of the instruction in EX/MEM
memwb_regwrite_i  input  1  RegWrite of the instruction in MEM/WB
memwb_rd_i  input  REG_AW  rd of the instruction in MEM/WB
valid_o  output  1  1 = real instruction in EX, 0 = bubble
rs1_data_o, rs2_data_o, imm_o  output  DATA_W  registered operands
rs1_addr_o, rs2_addr_o, rd_addr_o  output  REG_AW  registered indices
ctrl_o  output  CTRL_W  registered control
funct_o  output  FUNCT_W  registered funct
forward_a_o  output  2  select for operand-A 4-way mux
forward_b_o  output  2  select for operand-B 4-way mux

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Update priority at each rising edge, highest first: rst_i > flush_i > stall_i > normal load.
- rst_i: every registered output cleared to 0; valid_o = 0.
- flush_i (no reset):
  - All registered fields loaded with 0, including ctrl_o; valid_o = 0.
  - flush_i overrides a simultaneous stall_i.
- stall_i (no reset, no flush): all registered fields, including valid_o, hold their previous value.
- Normal load: every _o register takes its _i value on the edge; valid_o = 1. Latency is exactly 1 cycle, ID to EX.
- A bubble must never write: ctrl_o = 0 implies RegWrite = MemWrite = MemRead = 0.
- Forwarding selects are combinational from registered rs1/rs2 addresses and the live EX/MEM and MEM/WB inputs. No added latency.
- Select encoding, fixed for both operand muxes:
  - 00 = registered rs_data (register file)
  - 01 = MEM/WB write-back data
  - 10 = EX/MEM ALU result
  - 11 = reserved, never driven
- forward_a_o:
  - 10 if exmem_regwrite_i and exmem_rd_i != 0 and exmem_rd_i == rs1_addr_o.
  - Else 01 if memwb_regwrite_i and memwb_rd_i != 0 and memwb_rd_i == rs1_addr_o.
  - Else 00.
- forward_b_o: same rule against rs2_addr_o.
- EX/MEM has priority over MEM/WB when both match (youngest value wins).
- x0 is never forwarded: any rd of 0 forces 00.
- forward_*_o is forced to 00 when valid_o = 0.
- Mid-operation reset: an active rst_i overrides stall/flush on that edge. The register is cleared and valid_o = 0 the cycle after.

Decomposition:
- Shared package: CTRL_W; bit positions of RegWrite/MemtoReg/MemRead/MemWrite/ALUOp/ALUSrc within the control bundle; FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- The ALU operand mux uses the same FWD_* constants.
- One sub-module: fwd_sel, the combinational select generator, instantiated twice (rs1, rs2).

Test Plan:
- Reset then load: rst_i=1 for 1 edge -> all outputs 0. Then drive rs1_data_i=0x11, rd_addr_i=5, ctrl_i=7'h7F -> after 1 edge rs1_data_o=0x11, rd_addr_o=5, ctrl_o=0x7F, valid_o=1.
- Stall: with contents loaded, hold stall_i=1 for 3 cycles while inputs change to rs1_data_i=0x22 -> outputs stay 0x11. Release -> next edge shows 0x22.
- Flush vs stall: stall_i=1 and flush_i=1 on the same edge -> ctrl_o=0, valid_o=0, all data 0.
- Double hazard: rs1_addr_o=3, exmem rd=3/regwrite=1, memwb rd=3/regwrite=1 -> forward_a_o=10. Drop exmem_regwrite_i -> 01. Drop both -> 00.
- x0 and bubble: rs2_addr_o=0 with exmem_rd_i=0 and regwrite=1 -> forward_b_o=00. After a flush, with exmem_rd_i=0 -> forward_a_o=forward_b_o=00.
- Operand-B forwarding: rs2_addr_o=7, memwb rd=7, regwrite=1, exmem rd=8 -> forward_b_o=01 and forward_a_o unaffected.

Source files
------------

// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared definitions for the ID/EX register and EX-stage forwarding unit.
package id_ex_fwd_stage_pkg;

    // Control bundle layout: {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}
    localparam int unsigned CTRL_W        = 7;
    localparam int unsigned CTRL_REGWRITE = 6;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_MEMREAD  = 4;
    localparam int unsigned CTRL_MEMWRITE = 3;
    localparam int unsigned CTRL_ALUOP_HI = 2;
    localparam int unsigned CTRL_ALUOP_LO = 1;
    localparam int unsigned CTRL_ALUSRC   = 0;

    // Operand mux select encoding, shared with the ALU operand muxes.
    // 2'b11 is reserved and never produced.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,  // registered register-file data
        FWD_WB  = 2'b01,  // MEM/WB write-back data
        FWD_MEM = 2'b10   // EX/MEM ALU result
    } fwd_sel_e;

    // True when a control bundle would change architectural state.
    function automatic logic ctrl_has_effect(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMREAD] | ctrl[CTRL_MEMWRITE];
    endfunction

endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel.sv
// Combinational forwarding select for one ALU operand.
module fwd_sel
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              valid,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        sel
);

    logic exmem_hit;
    logic memwb_hit;

    // Producer match: x0 is never a forwarding source.
    always_comb begin
        exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_addr);
        memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_addr);
    end

    // Youngest producer (EX/MEM) wins; a bubble always reads the register file.
    always_comb begin
        sel = FWD_REG;
        if (valid) begin
            if (exmem_hit) begin
                sel = FWD_MEM;
            end else if (memwb_hit) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with the EX-stage forwarding select generator.
module id_ex_fwd_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned CTRL_W  = id_ex_fwd_stage_pkg::CTRL_W,
    parameter int unsigned FUNCT_W = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [DATA_W-1:0]  rs1_data_i,
    input  logic [DATA_W-1:0]  rs2_data_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [REG_AW-1:0]  rs1_addr_i,
    input  logic [REG_AW-1:0]  rs2_addr_i,
    input  logic [REG_AW-1:0]  rd_addr_i,
    input  logic [CTRL_W-1:0]  ctrl_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic               exmem_regwrite_i,
    input  logic [REG_AW-1:0]  exmem_rd_i,
    input  logic               memwb_regwrite_i,
    input  logic [REG_AW-1:0]  memwb_rd_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  rs1_data_o,
    output logic [DATA_W-1:0]  rs2_data_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [REG_AW-1:0]  rs1_addr_o,
    output logic [REG_AW-1:0]  rs2_addr_o,
    output logic [REG_AW-1:0]  rd_addr_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [FUNCT_W-1:0] funct_o,
    output logic [1:0]         forward_a_o,
    output logic [1:0]         forward_b_o
);

    // Pipeline register: reset > flush (bubble, overrides stall) > stall (hold) > load.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_o    <= 1'b0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rd_addr_o  <= '0;
            ctrl_o     <= '0;
            funct_o    <= '0;
        end else if (!stall_i) begin
            valid_o    <= 1'b1;
            rs1_data_o <= rs1_data_i;
            rs2_data_o <= rs2_data_i;
            imm_o      <= imm_i;
            rs1_addr_o <= rs1_addr_i;
            rs2_addr_o <= rs2_addr_i;
            rd_addr_o  <= rd_addr_i;
            ctrl_o     <= ctrl_i;
            funct_o    <= funct_i;
        end
    end

    fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .valid          (valid_o),
        .rs_addr        (rs1_addr_o),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_rd       (exmem_rd_i),
        .memwb_regwrite (memwb_regwrite_i),
        .memwb_rd       (memwb_rd_i),
        .sel            (forward_a_o)
    );

    fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .valid          (valid_o),
        .rs_addr        (rs2_addr_o),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_rd       (exmem_rd_i),
        .memwb_regwrite (memwb_regwrite_i),
        .memwb_rd       (memwb_rd_i),
        .sel            (forward_b_o)
    );

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Self-checking bench for id_ex_fwd_stage: directed stimulus, behavioural model.
module tb_id_ex_fwd_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [6:0]  ctrl_i;
    logic [9:0]  funct_i;
    logic        exmem_rw, memwb_rw;
    logic [4:0]  exmem_rd, memwb_rd;

    logic        valid_o;
    logic [31:0] rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [6:0]  ctrl_o;
    logic [9:0]  funct_o;
    logic [1:0]  forward_a_o, forward_b_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_fwd_stage #(
        .DATA_W  (32),
        .REG_AW  (5),
        .CTRL_W  (7),
        .FUNCT_W (10)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .flush_i          (flush),
        .rs1_data_i       (rs1_data_i),
        .rs2_data_i       (rs2_data_i),
        .imm_i            (imm_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs2_addr_i       (rs2_addr_i),
        .rd_addr_i        (rd_addr_i),
        .ctrl_i           (ctrl_i),
        .funct_i          (funct_i),
        .exmem_regwrite_i (exmem_rw),
        .exmem_rd_i       (exmem_rd),
        .memwb_regwrite_i (memwb_rw),
        .memwb_rd_i       (memwb_rd),
        .valid_o          (valid_o),
        .rs1_data_o       (rs1_data_o),
        .rs2_data_o       (rs2_data_o),
        .imm_o            (imm_o),
        .rs1_addr_o       (rs1_addr_o),
        .rs2_addr_o       (rs2_addr_o),
        .rd_addr_o        (rd_addr_o),
        .ctrl_o           (ctrl_o),
        .funct_o          (funct_o),
        .forward_a_o      (forward_a_o),
        .forward_b_o      (forward_b_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: the instruction currently sitting in EX.
    typedef struct {
        logic        valid;
        logic [31:0] rs1_data, rs2_data, imm;
        logic [4:0]  a1, a2, rd;
        logic [6:0]  ctrl;
        logic [9:0]  funct;
    } slot_t;

    slot_t ex;
    bit    known = 0;

    always @(posedge clk) begin
        if (rst) begin
            ex = '{default: '0};
            known = 1;
        end else if (flush) begin
            ex = '{default: '0};
        end else if (!stall) begin
            ex = '{1'b1, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i,
                   rd_addr_i, ctrl_i, funct_i};
        end
    end

    // Which producer supplies a source register: nearest writer of that register.
    function automatic logic [1:0] exp_fwd(input logic v, input logic [4:0] src);
        if (!v || src == 5'd0) return 2'b00;
        if (exmem_rw && exmem_rd == src) return 2'b10;
        if (memwb_rw && memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        if (known) begin
            chk("m_valid", 32'(valid_o), 32'(ex.valid));
            chk("m_rs1_data", rs1_data_o, ex.rs1_data);
            chk("m_rs2_data", rs2_data_o, ex.rs2_data);
            chk("m_imm", imm_o, ex.imm);
            chk("m_rs1_addr", 32'(rs1_addr_o), 32'(ex.a1));
            chk("m_rs2_addr", 32'(rs2_addr_o), 32'(ex.a2));
            chk("m_rd_addr", 32'(rd_addr_o), 32'(ex.rd));
            chk("m_ctrl", 32'(ctrl_o), 32'(ex.ctrl));
            chk("m_funct", 32'(funct_o), 32'(ex.funct));
            chk("m_fwd_a", 32'(forward_a_o), 32'(exp_fwd(ex.valid, ex.a1)));
            chk("m_fwd_b", 32'(forward_b_o), 32'(exp_fwd(ex.valid, ex.a2)));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
        ctrl_i = '0; funct_i = '0;
        exmem_rw = 0; exmem_rd = '0; memwb_rw = 0; memwb_rd = '0;

        // Reset
        tick;
        rst = 0;
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_rs1_data", rs1_data_o, 32'h0);
        chk("rst_ctrl", 32'(ctrl_o), 32'h0);
        chk("rst_fwd_a", 32'(forward_a_o), 32'h0);

        // Load
        rs1_data_i = 32'h11; rs2_data_i = 32'hAB; imm_i = 32'h1234;
        rd_addr_i = 5'd5; ctrl_i = 7'h7F; funct_i = 10'h155;
        rs1_addr_i = 5'd3; rs2_addr_i = 5'd7;
        tick;
        chk("load_rs1_data", rs1_data_o, 32'h11);
        chk("load_rd", 32'(rd_addr_o), 32'd5);
        chk("load_ctrl", 32'(ctrl_o), 32'h7F);
        chk("load_valid", 32'(valid_o), 32'h1);

        // Stall for three edges
        stall = 1; rs1_data_i = 32'h22;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall_hold", rs1_data_o, 32'h11);
        end
        stall = 0;
        tick;
        chk("stall_release", rs1_data_o, 32'h22);

        // Double hazard on rs1 = 3
        exmem_rw = 1; exmem_rd = 5'd3; memwb_rw = 1; memwb_rd = 5'd3;
        #1 chk("dbl_both", 32'(forward_a_o), 32'h2);
        tick;
        exmem_rw = 0;
        #1 chk("dbl_wb_only", 32'(forward_a_o), 32'h1);
        tick;
        memwb_rw = 0;
        #1 chk("dbl_none", 32'(forward_a_o), 32'h0);

        // Operand-B forwarding from MEM/WB, rs1 untouched
        tick;
        memwb_rd = 5'd7; memwb_rw = 1; exmem_rd = 5'd8; exmem_rw = 1;
        #1 chk("b_wb", 32'(forward_b_o), 32'h1);
        chk("b_a_unaffected", 32'(forward_a_o), 32'h0);
        tick;
        exmem_rd = 5'd3;
        #1 chk("a_mem_b_wb_a", 32'(forward_a_o), 32'h2);
        chk("a_mem_b_wb_b", 32'(forward_b_o), 32'h1);

        // x0 never forwarded
        rs2_addr_i = 5'd0;
        tick;
        exmem_rd = 5'd0; memwb_rw = 0;
        #1 chk("x0_fwd_b", 32'(forward_b_o), 32'h0);

        // Flush beats stall
        stall = 1; flush = 1;
        tick;
        stall = 0; flush = 0;
        chk("flush_ctrl", 32'(ctrl_o), 32'h0);
        chk("flush_valid", 32'(valid_o), 32'h0);
        chk("flush_rs1_data", rs1_data_o, 32'h0);
        chk("flush_rd", 32'(rd_addr_o), 32'h0);
        exmem_rd = 5'd0; exmem_rw = 1;
        #1 chk("bubble_fwd_a", 32'(forward_a_o), 32'h0);
        chk("bubble_fwd_b", 32'(forward_b_o), 32'h0);

        // Reset overrides stall and flush mid-operation
        tick;
        chk("pre_rst_valid", 32'(valid_o), 32'h1);
        rst = 1; stall = 1; flush = 1;
        tick;
        rst = 0; stall = 0; flush = 0;
        chk("mid_rst_valid", 32'(valid_o), 32'h0);
        chk("mid_rst_ctrl", 32'(ctrl_o), 32'h0);
        chk("mid_rst_rs1_data", rs1_data_o, 32'h0);

        // Mixed directed sequence, checked by the model every cycle
        for (int unsigned i = 0; i < 24; i++) begin
            rs1_data_i = 32'hA000_0000 + i;
            rs2_data_i = 32'hB000_0000 ^ (i << 4);
            imm_i      = 32'hFFFF_FFF0 + i;
            rs1_addr_i = 5'(i % 8);
            rs2_addr_i = 5'((i * 3) % 8);
            rd_addr_i  = 5'(31 - i);
            ctrl_i     = 7'(i * 13);
            funct_i    = 10'(i * 37);
            stall      = (i % 5 == 3);
            flush      = (i % 7 == 6);
            exmem_rw   = i[0];
            exmem_rd   = 5'((i + 1) % 8);
            memwb_rw   = i[1];
            memwb_rd   = 5'((i + 2) % 8);
            tick;
        end
        stall = 0; flush = 0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
